seven_segment_frame_monitor: RTL and testbench

Receive-side counterpart of the BCD-to-seven-segment encoding. The block snoops a multiplexed, active-low seven-segment display bus (segment pattern plus per-digit anode select) and recovers the BCD value and decimal point of every digit. It delivers a complete frame of digits atomically, with per-digit error flags. It sits beside the display driver for self-test and for loopback checking of the price/credit display.

---
 rtl/seven_seg_pkg.sv | 26 ++
 rtl/seven_segment_pattern_decode.sv | 32 +++
 rtl/seven_segment_frame_monitor.sv | 164 ++++++++++++++++
 tb/tb_seven_segment_frame_monitor.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment encoder/decoder pair: the active-low
// digit patterns (g..a), the special decode codes and the dwell FSM state type.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam logic [3:0] ERR_CODE   = 4'hE;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DWELL    = 2'd1,
        ST_CAPTURED = 2'd2
    } dwell_state_e;

endpackage

// File: rtl/seven_segment_pattern_decode.sv
// Combinational inverse of the BCD-to-seven-segment encoder: maps one active-low
// segment byte to {code, dp, err}; unknown patterns decode to ERR_CODE.
module seven_segment_pattern_decode
    import seven_seg_pkg::*;
(
    input  logic [7:0] segment,
    output logic [3:0] code,
    output logic       dp,
    output logic       err
);

    always_comb begin
        code = ERR_CODE;
        err  = 1'b1;
        dp   = ~segment[7];
        case (segment[6:0])
            SEG_0:     begin code = 4'd0;       err = 1'b0; end
            SEG_1:     begin code = 4'd1;       err = 1'b0; end
            SEG_2:     begin code = 4'd2;       err = 1'b0; end
            SEG_3:     begin code = 4'd3;       err = 1'b0; end
            SEG_4:     begin code = 4'd4;       err = 1'b0; end
            SEG_5:     begin code = 4'd5;       err = 1'b0; end
            SEG_6:     begin code = 4'd6;       err = 1'b0; end
            SEG_7:     begin code = 4'd7;       err = 1'b0; end
            SEG_8:     begin code = 4'd8;       err = 1'b0; end
            SEG_9:     begin code = 4'd9;       err = 1'b0; end
            SEG_BLANK: begin code = BLANK_CODE; err = 1'b0; end
            default:   begin code = ERR_CODE;   err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seven_segment_frame_monitor.sv
// Snoops a multiplexed active-low seven-segment bus, captures each digit once it
// has dwelt stably, and publishes a whole frame atomically when every digit is seen.
module seven_segment_frame_monitor
    import seven_seg_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            segment_data,
    input  logic [DIGITS-1:0]     digit_sel,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     dp_out,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  frame_valid,
    output logic                  frame_err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int ZW = $clog2(DIGITS + 1);

    logic [7:0]        seg_q, prev_seg;
    logic [DIGITS-1:0] sel_q, prev_sel;
    dwell_state_e      state, state_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic              capture;

    logic [ZW-1:0]     low_count;
    logic [IW-1:0]     digit_idx;
    logic              sample_valid;
    logic              sample_same;

    logic [3:0]        dec_code;
    logic              dec_dp, dec_err;

    logic [3:0]        shadow_code [DIGITS];
    logic [DIGITS-1:0] shadow_dp, shadow_err;
    logic [DIGITS-1:0] seen, seen_nx, capture_mask;
    logic [3:0]        commit_code [DIGITS];
    logic [DIGITS-1:0] commit_dp, commit_err;
    logic              commit;

    seven_segment_pattern_decode u_decode (
        .segment (seg_q),
        .code    (dec_code),
        .dp      (dec_dp),
        .err     (dec_err)
    );

    // A sample is usable only when exactly one anode is driven low.
    always_comb begin
        low_count = '0;
        digit_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!sel_q[i]) begin
                low_count = low_count + ZW'(1);
                digit_idx = i[IW-1:0];
            end
        end
    end

    assign sample_valid = (low_count == ZW'(1));
    assign sample_same  = (seg_q == prev_seg) && (sel_q == prev_sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q    <= 8'hFF;
            sel_q    <= '1;
            prev_seg <= 8'hFF;
            prev_sel <= '1;
            state    <= ST_IDLE;
            cnt      <= '0;
        end else begin
            seg_q    <= segment_data;
            sel_q    <= digit_sel;
            prev_seg <= seg_q;
            prev_sel <= sel_q;
            state    <= state_nx;
            cnt      <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        capture  = 1'b0;
        if (!sample_valid) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_DWELL;
                    cnt_nx   = CW'(1);
                end
                ST_DWELL: begin
                    if (!sample_same) begin
                        cnt_nx = CW'(1);
                    end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                        capture  = 1'b1;
                        state_nx = ST_CAPTURED;
                        cnt_nx   = CW'(STABLE_CYCLES);
                    end else begin
                        cnt_nx = cnt + CW'(1);
                    end
                end
                ST_CAPTURED: begin
                    if (!sample_same) begin
                        state_nx = ST_DWELL;
                        cnt_nx   = CW'(1);
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // The frame view includes a capture landing on this same edge.
    always_comb begin
        capture_mask = '0;
        if (capture) capture_mask[digit_idx] = 1'b1;
        seen_nx = seen | capture_mask;
        commit  = capture && (&seen_nx);
        for (int i = 0; i < DIGITS; i++) begin
            commit_code[i] = capture_mask[i] ? dec_code : shadow_code[i];
            commit_dp[i]   = capture_mask[i] ? dec_dp   : shadow_dp[i];
            commit_err[i]  = capture_mask[i] ? dec_err  : shadow_err[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) shadow_code[i] <= BLANK_CODE;
            shadow_dp   <= '0;
            shadow_err  <= '0;
            seen        <= '0;
            bcd_out     <= {DIGITS{BLANK_CODE}};
            dp_out      <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= commit;
            seen        <= commit ? '0 : seen_nx;
            if (capture) begin
                shadow_code[digit_idx] <= dec_code;
                shadow_dp[digit_idx]   <= dec_dp;
                shadow_err[digit_idx]  <= dec_err;
            end
            if (commit) begin
                for (int i = 0; i < DIGITS; i++) bcd_out[4*i +: 4] <= commit_code[i];
                dp_out    <= commit_dp;
                digit_err <= commit_err;
                frame_err <= |commit_err;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_frame_monitor.sv
// Directed bench for the seven-segment frame monitor: scans digits onto the bus
// and scoreboards every committed frame against frames queued when the scan is driven.
module tb_seven_segment_frame_monitor;

    localparam int DIGITS = 4;

    logic                clk;
    logic                rst_n;
    logic [7:0]          segment_data;
    logic [DIGITS-1:0]   digit_sel;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   dp_out;
    logic [DIGITS-1:0]   digit_err;
    logic                frame_valid;
    logic                frame_err;

    typedef logic [24:0] frame_t;
    frame_t exp_q[$];

    int n_vec    = 0;
    int n_err    = 0;
    int n_frames = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    seven_segment_frame_monitor #(.DIGITS(DIGITS), .STABLE_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .segment_data (segment_data),
        .digit_sel    (digit_sel),
        .bcd_out      (bcd_out),
        .dp_out       (dp_out),
        .digit_err    (digit_err),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int d, input logic dp);
        logic [6:0] s;
        s = seg_tab[d];
        return {~dp, s};
    endfunction

    function automatic frame_t observed();
        return {bcd_out, dp_out, digit_err, frame_err};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // driver: put digit d on the bus at a falling edge and keep it for n rising edges
    task automatic show(input int d, input logic [7:0] seg, input int n);
        @(negedge clk);
        segment_data = seg;
        digit_sel    = 4'hF & ~(4'b0001 << d);
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        segment_data = 8'hFF;
        digit_sel    = 4'hF;
        repeat (n - 1) @(negedge clk);
    endtask

    // scoreboard: every frame_valid pulse consumes one queued frame
    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_valid === 1'b1) begin
            n_frames++;
            n_vec++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_frame: observed %h expected none", observed());
            end
            if (exp_q.size() != 0) check("frame", 32'(observed()), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        rst_n        = 1'b0;
        segment_data = 8'hFF;
        digit_sel    = 4'hF;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(observed()), 32'({16'hFFFF, 4'h0, 4'h0, 1'b0}));
        check("reset_frame_valid", 32'(frame_valid), 32'(0));
        rst_n = 1'b1;

        // plain frame 1,2,3,4
        show(0, pat(1, 1'b0), 6);
        show(1, pat(2, 1'b0), 6);
        show(2, pat(3, 1'b0), 6);
        exp_q.push_back({16'h4321, 4'h0, 4'h0, 1'b0});
        show(3, pat(4, 1'b0), 6);
        idle(2);
        check("frames_after_first", 32'(n_frames), 32'(1));

        // dp, blank and invalid patterns
        show(0, pat(5, 1'b0), 6);
        show(1, 8'hFF, 6);
        show(2, 8'h00, 6);
        exp_q.push_back({16'hE8F5, 4'b0100, 4'b1000, 1'b1});
        show(3, 8'hFE, 6);
        idle(2);
        check("frames_after_special", 32'(n_frames), 32'(2));

        // digit 0 too short: three rising edges only
        show(0, pat(7, 1'b0), 3);
        show(1, pat(1, 1'b0), 6);
        show(2, pat(2, 1'b0), 6);
        show(3, pat(3, 1'b0), 6);
        idle(3);
        check("frames_after_glitch", 32'(n_frames), 32'(2));
        check("held_after_glitch", 32'(observed()), 32'({16'hE8F5, 4'b0100, 4'b1000, 1'b1}));
        exp_q.push_back({16'h3217, 4'h0, 4'h0, 1'b0});
        show(0, pat(7, 1'b0), 4);
        idle(3);
        check("frames_after_min_hold", 32'(n_frames), 32'(3));

        // two anodes low does not capture nor clear the seen mask
        show(0, pat(6, 1'b0), 6);
        @(negedge clk);
        segment_data = pat(8, 1'b0);
        digit_sel    = 4'b0011;
        repeat (9) @(negedge clk);
        check("frames_after_two_low", 32'(n_frames), 32'(3));
        show(1, pat(7, 1'b0), 6);
        show(2, pat(8, 1'b0), 6);
        exp_q.push_back({16'h9876, 4'h0, 4'h0, 1'b0});
        show(3, pat(9, 1'b0), 6);
        idle(2);
        check("frames_after_two_low_scan", 32'(n_frames), 32'(4));

        // reset with half a frame captured
        show(0, pat(2, 1'b0), 6);
        show(1, pat(4, 1'b1), 6);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 32'(observed()), 32'({16'hFFFF, 4'h0, 4'h0, 1'b0}));
        check("midreset_frame_valid", 32'(frame_valid), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        show(2, pat(0, 1'b0), 6);
        show(3, pat(5, 1'b0), 6);
        idle(3);
        check("frames_after_reset_partial", 32'(n_frames), 32'(4));
        show(0, pat(1, 1'b1), 6);
        exp_q.push_back({16'h5091, 4'b0001, 4'h0, 1'b0});
        show(1, pat(9, 1'b0), 6);
        idle(4);
        check("frames_total", 32'(n_frames), 32'(5));
        check("queue_drained", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
